// File: rtl/lfsr_rng_pkg.sv
// lfsr_rng_pkg: shared tap constants, default seed, control states and range-mask helper.
package lfsr_rng_pkg;
    localparam logic [7:0]  TAPS_8          = 8'hB8;
    localparam logic [15:0] TAPS_16         = 16'hB400;
    localparam logic [23:0] TAPS_24         = 24'hE10000;
    localparam logic [31:0] TAPS_32         = 32'h80200003;
    localparam logic [15:0] DEFAULT_SEED_16 = 16'hACE1;
    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_LOAD} state_e;
    // Smear the top set bit downward: smallest 2^k-1 covering r (0 stays 0).
    function automatic logic [31:0] range_mask(input logic [31:0] r);
        logic [31:0] m;
        m = r;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction
endpackage

// File: rtl/lfsr_rng_if.sv
// lfsr_rng_if: control inputs and valid/ready result port of the random source.
interface lfsr_rng_if #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 8
);
    logic             en;
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic [OUT_W-1:0] range_max;
    logic             out_ready;
    logic             out_valid;
    logic [OUT_W-1:0] rand_out;
    logic             seed_zero;
    logic             rej_fallback;
    modport master (
        output en, seed_load, seed, range_max, out_ready,
        input  out_valid, rand_out, seed_zero, rej_fallback
    );
    modport slave (
        input  en, seed_load, seed, range_max, out_ready,
        output out_valid, rand_out, seed_zero, rej_fallback
    );
endinterface

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR state with seed loading and zero-state substitution.
module lfsr_core #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state
);
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_shift;
    assign w_shift = {r_state[WIDTH-2:0], ^(r_state & TAPS)};
    assign state   = r_state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= DEFAULT_SEED;
        else if (load)
            r_state <= (seed == '0) ? DEFAULT_SEED : seed;
        else if (step)
            r_state <= (w_shift == '0) ? DEFAULT_SEED : w_shift;
    end
endmodule

// File: rtl/lfsr_rng.sv
// lfsr_rng: LFSR random source with bounded-range rejection sampling and a
// one-entry valid/ready output register.
module lfsr_rng
    import lfsr_rng_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = TAPS_16,
    parameter int               OUT_W        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = DEFAULT_SEED_16,
    parameter int               REJ_LIMIT    = 4
) (
    input logic       clk,
    input logic       rst_n,
    lfsr_rng_if.slave bus
);
    localparam int RW = $clog2(REJ_LIMIT + 1);
    localparam logic [RW-1:0] REJ_LAST = RW'(REJ_LIMIT - 1);
    logic [WIDTH-1:0] w_lfsr;
    logic [OUT_W-1:0] w_mask, w_cand;
    logic             w_slot_free, w_adv, w_in_range, w_accept, w_fallback, w_produce;
    logic [OUT_W-1:0] r_rand_out;
    logic             r_out_valid, r_seed_zero, r_rej_fallback;
    logic [RW-1:0]    r_rej_cnt;
    state_e           r_state, w_state_nxt;
    lfsr_core #(
        .WIDTH       (WIDTH),
        .TAPS        (TAPS),
        .DEFAULT_SEED(DEFAULT_SEED)
    ) u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .step (w_adv),
        .load (bus.seed_load),
        .seed (bus.seed),
        .state(w_lfsr)
    );
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_adv       = bus.en && w_slot_free && !bus.seed_load;
    assign w_mask      = OUT_W'(range_mask(32'(bus.range_max)));
    assign w_cand      = w_lfsr[OUT_W-1:0] & w_mask;
    assign w_in_range  = w_cand <= bus.range_max;
    assign w_accept    = w_adv && w_in_range;
    assign w_fallback  = w_adv && !w_in_range && (r_rej_cnt == REJ_LAST);
    assign w_produce   = w_accept || w_fallback;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rand_out     <= '0;
            r_out_valid    <= 1'b0;
            r_rej_cnt      <= '0;
            r_seed_zero    <= 1'b0;
            r_rej_fallback <= 1'b0;
        end else begin
            r_seed_zero    <= bus.seed_load && (bus.seed == '0);
            r_rej_fallback <= w_fallback;
            if (bus.seed_load) begin
                r_out_valid <= 1'b0;
                r_rej_cnt   <= '0;
            end else if (w_produce) begin
                // cand <= 2*range_max+1 here, so the wrap lands inside 0..range_max
                r_rand_out  <= w_accept ? w_cand : w_cand - bus.range_max - 1'b1;
                r_out_valid <= 1'b1;
                r_rej_cnt   <= '0;
            end else begin
                if (w_adv)
                    r_rej_cnt <= r_rej_cnt + 1'b1;
                if (bus.out_ready)
                    r_out_valid <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = r_state;
        if (bus.seed_load)
            w_state_nxt = ST_LOAD;
        else if (w_produce && !bus.out_ready)
            w_state_nxt = ST_HOLD;
        else if (r_state != ST_HOLD || bus.out_ready)
            w_state_nxt = ST_RUN;
    end
    assign bus.out_valid    = r_out_valid;
    assign bus.rand_out     = r_rand_out;
    assign bus.seed_zero    = r_seed_zero;
    assign bus.rej_fallback = r_rej_fallback;
endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: directed checks of sequence, period, rejection, fallback, hold,
// zero seed and asynchronous reset.
module tb_lfsr_rng;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, seed_load, out_ready;
    logic [15:0] seed;
    logic [7:0]  range_max;
    int          n_cmp = 0;
    int          n_err = 0;
    lfsr_rng_if #(.WIDTH(16), .OUT_W(8)) a_if ();
    lfsr_rng_if #(.WIDTH(16), .OUT_W(8)) b_if ();
    assign a_if.en = en;        assign b_if.en = en;
    assign a_if.seed_load = seed_load; assign b_if.seed_load = seed_load;
    assign a_if.seed = seed;    assign b_if.seed = seed;
    assign a_if.range_max = range_max; assign b_if.range_max = range_max;
    assign a_if.out_ready = out_ready; assign b_if.out_ready = out_ready;
    lfsr_rng #(.REJ_LIMIT(4)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(a_if));
    lfsr_rng #(.REJ_LIMIT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b_if));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [7:0] exp_seq [9];
        int first_ret, zero_seen;
        exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
        rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; out_ready = 1'b0;
        seed = '0; range_max = 8'hFF;
        tick(); tick();
        chk("rst_valid", 32'(a_if.out_valid), 0);
        chk("rst_rand", 32'(a_if.rand_out), 0);
        chk("rst_seed_zero", 32'(a_if.seed_zero), 0);
        chk("rst_fallback", 32'(a_if.rej_fallback), 0);
        chk("rst_lfsr", 32'(u_dut.w_lfsr), 32'hACE1);
        rst_n = 1'b1;
        tick();
        seed_load = 1'b1; seed = 16'h0001; en = 1'b1; out_ready = 1'b1;
        tick();
        chk("load1_lfsr", 32'(u_dut.w_lfsr), 32'h0001);
        chk("load1_valid", 32'(a_if.out_valid), 0);
        seed_load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("seq%0d", i), 32'(a_if.rand_out), 32'(exp_seq[i]));
            chk($sformatf("seq_valid%0d", i), 32'(a_if.out_valid), 1);
        end
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        first_ret = 0; zero_seen = 0;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (u_dut.w_lfsr == 16'h0000) zero_seen++;
            if (u_dut.w_lfsr == 16'h0001 && first_ret == 0) first_ret = i;
        end
        chk("period", 32'(first_ret), 65535);
        chk("never_zero", 32'(zero_seen), 0);
        seed_load = 1'b1; seed = 16'h0003; range_max = 8'h02;
        tick();
        chk("load3_lfsr", 32'(u_dut.w_lfsr), 32'h0003);
        seed_load = 1'b0;
        tick();
        chk("rej_valid", 32'(a_if.out_valid), 0);
        chk("fb1_valid", 32'(b_if.out_valid), 1);
        chk("fb1_rand", 32'(b_if.rand_out), 0);
        chk("fb1_pulse", 32'(b_if.rej_fallback), 1);
        tick();
        chk("acc_valid", 32'(a_if.out_valid), 1);
        chk("acc_rand", 32'(a_if.rand_out), 2);
        chk("acc_no_fb", 32'(a_if.rej_fallback), 0);
        chk("fb1_pulse_end", 32'(b_if.rej_fallback), 0);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("hold_rand", 32'(a_if.rand_out), 2);
        chk("hold_valid", 32'(a_if.out_valid), 1);
        chk("hold_lfsr", 32'(u_dut.w_lfsr), 32'h000C);
        out_ready = 1'b1; range_max = 8'hFF;
        tick();
        chk("release_rand", 32'(a_if.rand_out), 32'h0C);
        chk("release_valid", 32'(a_if.out_valid), 1);
        tick();
        chk("next_rand", 32'(a_if.rand_out), 32'h18);
        seed_load = 1'b1; seed = 16'h0000;
        tick();
        chk("zseed_pulse", 32'(a_if.seed_zero), 1);
        chk("zseed_lfsr", 32'(u_dut.w_lfsr), 32'hACE1);
        chk("zseed_valid", 32'(a_if.out_valid), 0);
        seed_load = 1'b0; en = 1'b0;
        tick();
        chk("zseed_pulse_end", 32'(a_if.seed_zero), 0);
        chk("en0_lfsr", 32'(u_dut.w_lfsr), 32'hACE1);
        en = 1'b1; out_ready = 1'b0;
        tick();
        chk("pre_rst_rand", 32'(a_if.rand_out), 32'hE1);
        chk("pre_rst_valid", 32'(a_if.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(a_if.out_valid), 0);
        chk("arst_rand", 32'(a_if.rand_out), 0);
        chk("arst_lfsr", 32'(u_dut.w_lfsr), 32'hACE1);
        tick();
        rst_n = 1'b1; en = 1'b0;
        tick();
        chk("post_rst_lfsr", 32'(u_dut.w_lfsr), 32'hACE1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
